// File: rtl/ev19_irq_ctrl.sv
// Interrupt controller for the EV19 core: captures up to 16 peripheral lines,
// masks and prioritises them, and exposes claim/complete over an Avalon-MM slave.
module ev19_irq_ctrl #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [15:0] EDGE_RESET = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               read_n,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               cpu_irq
);

  // Bits at or above NUM_IRQ are tied off everywhere through this mask.
  localparam logic [15:0] VALID_MASK = 16'hFFFF >> (16 - NUM_IRQ);

  localparam logic [2:0] ADDR_PENDING    = 3'd0;
  localparam logic [2:0] ADDR_ENABLE     = 3'd1;
  localparam logic [2:0] ADDR_EDGE_MODE  = 3'd2;
  localparam logic [2:0] ADDR_CLAIM      = 3'd3;
  localparam logic [2:0] ADDR_IN_SERVICE = 3'd4;
  localparam logic [2:0] ADDR_ACTIVE     = 3'd5;

  logic [15:0] pending;
  logic [15:0] enable;
  logic [15:0] edge_mode;
  logic [15:0] in_service;
  logic [15:0] irq_d;

  logic [15:0] irq_ext;
  logic [15:0] rise;
  logic [15:0] active;
  logic [4:0]  claim_id;
  logic        wr;
  logic        rd;
  logic        claim;
  logic [15:0] claim_mask;
  logic [15:0] complete_mask;
  logic [15:0] w1c_mask;
  logic [15:0] pending_next;
  logic [15:0] read_mux;

  assign irq_ext = 16'(irq_in) & VALID_MASK;
  assign rise    = irq_ext & ~irq_d;
  assign active  = pending & enable & ~in_service;

  assign wr = chipselect & ~write_n;
  assign rd = chipselect & ~read_n;

  // Lowest index wins, so scan from the top and let lower hits overwrite.
  always_comb begin
    claim_id = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (active[i]) claim_id = 5'(i + 1);
    end
  end

  assign claim = rd && (address == ADDR_CLAIM) && (claim_id != 5'd0);

  always_comb begin
    claim_mask    = 16'h0000;
    complete_mask = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      claim_mask[i]    = claim && (claim_id == 5'(i + 1));
      complete_mask[i] = wr && (address == ADDR_CLAIM) && (writedata == 16'(i + 1));
    end
    claim_mask    = claim_mask & VALID_MASK;
    complete_mask = complete_mask & VALID_MASK;
  end

  assign w1c_mask = (wr && (address == ADDR_PENDING)) ? (writedata & edge_mode) : 16'h0000;

  // Edge bits: a same-cycle rise beats any clear. Level bits just follow the line.
  assign pending_next = ((edge_mode & ((pending & ~(claim_mask | w1c_mask)) | rise)) |
                         (~edge_mode & irq_ext)) & VALID_MASK;

  always_comb begin
    read_mux = 16'h0000;
    case (address)
      ADDR_PENDING:    read_mux = pending;
      ADDR_ENABLE:     read_mux = enable;
      ADDR_EDGE_MODE:  read_mux = edge_mode;
      ADDR_CLAIM:      read_mux = {11'd0, claim_id};
      ADDR_IN_SERVICE: read_mux = in_service;
      ADDR_ACTIVE:     read_mux = active;
      default:         read_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_d      <= 16'h0000;
      pending    <= 16'h0000;
      enable     <= 16'h0000;
      edge_mode  <= EDGE_RESET & VALID_MASK;
      in_service <= 16'h0000;
      readdata   <= 16'h0000;
      cpu_irq    <= 1'b0;
    end else begin
      irq_d      <= irq_ext;
      pending    <= pending_next;
      in_service <= (in_service | claim_mask) & ~complete_mask;
      cpu_irq    <= |active;
      if (wr && (address == ADDR_ENABLE))    enable    <= writedata & VALID_MASK;
      if (wr && (address == ADDR_EDGE_MODE)) edge_mode <= writedata & VALID_MASK;
      if (rd) readdata <= read_mux;
    end
  end

endmodule

// File: tb/tb_ev19_irq_ctrl.sv
// Directed self-checking bench for ev19_irq_ctrl with NUM_IRQ=8.
module tb_ev19_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic [7:0]  irq_in;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        cpu_irq;

  int errors = 0;
  int checks = 0;
  logic [15:0] rdata;

  ev19_irq_ctrl #(.NUM_IRQ(8), .EDGE_RESET(16'h0000)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .irq_in     (irq_in),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .cpu_irq    (cpu_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] lines);
    irq_in = lines;
  endtask

  task automatic busWrite(input logic [2:0] addr, input logic [15:0] data);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = addr;
    writedata  = data;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic busRead(input logic [2:0] addr, output logic [15:0] data);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = addr;
    step();
    chipselect = 1'b0;
    read_n     = 1'b1;
    data       = readdata;
  endtask

  initial begin
    reset_n    = 1'b0;
    irq_in     = 8'h00;
    address    = 3'd0;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    writedata  = 16'h0000;
    step();
    step();
    checkOutput("reset_readdata", readdata, 16'h0000);
    checkOutput("reset_cpu_irq", {15'd0, cpu_irq}, 16'h0000);
    reset_n = 1'b1;
    step();
    busRead(3'd0, rdata); checkOutput("reset_pending", rdata, 16'h0000);
    busRead(3'd1, rdata); checkOutput("reset_enable", rdata, 16'h0000);
    busRead(3'd2, rdata); checkOutput("reset_edge_mode", rdata, 16'h0000);

    // Edge source 0: pulse, capture, claim, complete
    busWrite(3'd1, 16'h0001);
    busWrite(3'd2, 16'h0001);
    applyStimulus(8'h01);
    step();
    applyStimulus(8'h00);
    checkOutput("t1_cpu_irq_early", {15'd0, cpu_irq}, 16'h0000);
    busRead(3'd0, rdata); checkOutput("t1_pending", rdata, 16'h0001);
    checkOutput("t1_cpu_irq_set", {15'd0, cpu_irq}, 16'h0001);
    busRead(3'd3, rdata); checkOutput("t1_claim", rdata, 16'h0001);
    step();
    checkOutput("t1_cpu_irq_drop", {15'd0, cpu_irq}, 16'h0000);
    busRead(3'd0, rdata); checkOutput("t1_pending_cleared", rdata, 16'h0000);
    busRead(3'd4, rdata); checkOutput("t1_in_service", rdata, 16'h0001);
    busWrite(3'd3, 16'h0001);
    busRead(3'd4, rdata); checkOutput("t1_complete", rdata, 16'h0000);

    // Level sources 2 and 5 with nested claims
    busWrite(3'd2, 16'h0000);
    busWrite(3'd1, 16'h0024);
    applyStimulus(8'h24);
    step();
    step();
    busRead(3'd3, rdata); checkOutput("t2_claim_a", rdata, 16'h0003);
    busRead(3'd3, rdata); checkOutput("t2_claim_b", rdata, 16'h0006);
    busRead(3'd3, rdata); checkOutput("t2_claim_none", rdata, 16'h0000);
    checkOutput("t2_cpu_irq_low", {15'd0, cpu_irq}, 16'h0000);
    busRead(3'd4, rdata); checkOutput("t2_in_service", rdata, 16'h0024);
    busWrite(3'd3, 16'h0003);
    step();
    checkOutput("t2_cpu_irq_reraise", {15'd0, cpu_irq}, 16'h0001);
    applyStimulus(8'h00);
    busWrite(3'd3, 16'h0006);
    step();
    step();

    // Rise on edge source 1 in the same cycle as a W1C clear
    busWrite(3'd1, 16'h0000);
    busWrite(3'd2, 16'h0002);
    applyStimulus(8'h02);
    busWrite(3'd0, 16'h0002);
    busRead(3'd0, rdata); checkOutput("t3_set_wins", rdata, 16'h0002);
    busWrite(3'd0, 16'h0002);
    busRead(3'd0, rdata); checkOutput("t3_w1c", rdata, 16'h0000);
    applyStimulus(8'h00);

    // Out-of-range completes, empty claim, unmapped and masked-off bits
    busWrite(3'd2, 16'h0000);
    busWrite(3'd1, 16'h0001);
    applyStimulus(8'h01);
    step();
    step();
    busRead(3'd3, rdata); checkOutput("t4_claim", rdata, 16'h0001);
    busWrite(3'd3, 16'h0000);
    busWrite(3'd3, 16'h0009);
    busWrite(3'd3, 16'h8001);
    busRead(3'd4, rdata); checkOutput("t4_bad_complete", rdata, 16'h0001);
    busRead(3'd3, rdata); checkOutput("t4_empty_claim", rdata, 16'h0000);
    busRead(3'd4, rdata); checkOutput("t4_no_change", rdata, 16'h0001);
    busRead(3'd0, rdata); checkOutput("t4_level_kept", rdata, 16'h0001);
    busWrite(3'd3, 16'h0001);
    busRead(3'd4, rdata); checkOutput("t4_complete", rdata, 16'h0000);
    applyStimulus(8'h00);
    busWrite(3'd1, 16'hFFFF);
    busRead(3'd1, rdata); checkOutput("t4_enable_width", rdata, 16'h00FF);
    busWrite(3'd6, 16'h1234);
    busRead(3'd6, rdata); checkOutput("t4_addr6", rdata, 16'h0000);
    busWrite(3'd1, 16'h0000);

    // Enable toggled while an edge source is pending
    busWrite(3'd2, 16'h0010);
    busWrite(3'd1, 16'h0010);
    applyStimulus(8'h10);
    step();
    applyStimulus(8'h00);
    step();
    checkOutput("t5_cpu_irq_set", {15'd0, cpu_irq}, 16'h0001);
    busWrite(3'd1, 16'h0000);
    step();
    checkOutput("t5_cpu_irq_masked", {15'd0, cpu_irq}, 16'h0000);
    busRead(3'd0, rdata); checkOutput("t5_pending_kept", rdata, 16'h0010);
    busWrite(3'd1, 16'h0010);
    step();
    checkOutput("t5_cpu_irq_unmasked", {15'd0, cpu_irq}, 16'h0001);
    busWrite(3'd0, 16'h0010);
    busWrite(3'd2, 16'h0000);

    // Asynchronous reset in the middle of a claim
    busWrite(3'd1, 16'h0007);
    applyStimulus(8'h07);
    step();
    step();
    busRead(3'd3, rdata); checkOutput("t6_claim_a", rdata, 16'h0001);
    busRead(3'd3, rdata); checkOutput("t6_claim_b", rdata, 16'h0002);
    busRead(3'd4, rdata); checkOutput("t6_in_service", rdata, 16'h0003);
    step();
    checkOutput("t6_cpu_irq_pre", {15'd0, cpu_irq}, 16'h0001);
    chipselect = 1'b1;
    read_n     = 1'b0;
    address    = 3'd3;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_async_readdata", readdata, 16'h0000);
    checkOutput("t6_async_cpu_irq", {15'd0, cpu_irq}, 16'h0000);
    chipselect = 1'b0;
    read_n     = 1'b1;
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    busRead(3'd0, rdata); checkOutput("t6_level_retrigger", rdata, 16'h0007);
    busRead(3'd1, rdata); checkOutput("t6_enable_reset", rdata, 16'h0000);
    busRead(3'd4, rdata); checkOutput("t6_in_service_reset", rdata, 16'h0000);
    checkOutput("t6_cpu_irq_after", {15'd0, cpu_irq}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ev19_irq_ctrl.md
Name: ev19_irq_ctrl

Overview:
- Memory-mapped interrupt controller that sits directly downstream of the SoC timer and the other peripheral interrupt sources.
- Captures up to 16 peripheral IRQ lines, masks and prioritises them, and drives a single external-interrupt request to the EV19 RISC-V core.
- Provides a claim/complete handshake so firmware can identify and retire the active source.
- Avalon-MM slave: 16-bit data, read latency 1 (registered readdata), no wait states.

Parameters:
NUM_IRQ, 8, number of interrupt inputs; legal range 1..16.
EDGE_RESET, 16'h0000, reset value of the edge-mode register (bit=1: source is edge-triggered).

Ports:
clk  input  1  system clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
irq_in  input  NUM_IRQ  peripheral interrupt lines, synchronous to clk, active high (bit 0 = timer irq)
address  input  3  word address of slave register
chipselect  input  1  slave select
read_n  input  1  active-low read strobe
write_n  input  1  active-low write strobe
writedata  input  16  write data
readdata  output  16  registered read data
cpu_irq  output  1  external-interrupt request to core, registered

Behaviour:
- Reset: clk and reset_n only; reset_n asynchronous active-low. Outputs and state after reset:
  - readdata=0, cpu_irq=0.
  - pending=0, enable=0, in_service=0, irq_d=0.
  - edge_mode=EDGE_RESET.
- Register map (bits >= NUM_IRQ read 0 and ignore writes):
  - addr0 PENDING: read pending. Write 1 to clear bits of edge sources only; level bits ignore the write.
  - addr1 ENABLE: R/W mask.
  - addr2 EDGE_MODE: R/W.
  - addr3 CLAIM/COMPLETE: read = claim; write = complete.
  - addr4 IN_SERVICE: RO.
  - addr5 ACTIVE: RO, pending & enable & ~in_service.
  - addr6, addr7: read 0, writes ignored.
- Strobes:
  - wr = chipselect & ~write_n.
  - rd = chipselect & ~read_n.
  - One access per cycle; the master never asserts both.
- Edge capture: irq_d <= irq_in every cycle; rise = irq_in & ~irq_d.
- Pending update, per bit i, each cycle:
  - Edge source: set on rise[i]; clear on a claim of i or a W1C write. Set wins over a same-cycle clear.
  - Level source: pending[i] = irq_in[i] registered (follows the line one cycle late). Claim does not clear it; in_service masks it instead.
  - Changing edge_mode[i] does not alter the current pending[i] value in that cycle.
- Priority: lowest index wins among active = pending & enable & ~in_service. id = index+1; id 0 means none.
- Claim (rd at addr3):
  - readdata <= id on the next edge.
  - If id != 0, on the same edge: in_service[id-1] <= 1, and pending[id-1] <= 0 if that source is edge mode (unless a new rise occurs in the same cycle).
  - If id = 0: no state change.
- Complete (wr at addr3): if 1 <= writedata <= NUM_IRQ, clear in_service[writedata-1]. Otherwise, or if that bit is already clear, no effect.
- Other reads: readdata <= selected register on the next edge. When not reading, readdata holds its last value.
- cpu_irq <= |active, registered. Latency is 2 cycles from an irq_in rising edge to cpu_irq=1 (capture, then register). cpu_irq deasserts one cycle after the claim edge when no other source is active.
- Enable cleared while pending: pending is kept; cpu_irq drops the next cycle. The source re-raises cpu_irq when enable is set again.
- Nesting: multiple in_service bits may be set at once. Claim always returns the highest-priority source that is not in service.
- Reset mid-operation: all state returns to reset values immediately. Sources that are still high retrigger as follows:
  - Level sources: pending on the next cycle.
  - Edge sources: only on a fresh rise (irq_d is reset to 0, so a line already high reads as a rise on the first cycle after reset).

Test Plan:
1. Enable=0x0001, edge_mode[0]=1, pulse irq_in[0] for 1 cycle -> pending=0x0001 one cycle later, cpu_irq=1 two cycles after the pulse. Read addr3 -> readdata=1, pending=0, in_service=0x0001, cpu_irq=0. Write 1 to addr3 -> in_service=0.
2. Level sources 2 and 5 held high, enable=0x0024 -> claim returns 3; a second claim returns 6; a third claim returns 0. cpu_irq=0 after the second claim. Complete 3 -> cpu_irq=1 again (line 2 still high).
3. Edge source 1: rise in the same cycle as a W1C write of 0x0002 to addr0 -> pending[1] stays 1 (set wins).
4. Write 0, 9 (with NUM_IRQ=8) and 0x8001 to addr3 -> in_service unchanged. Claim with nothing active -> readdata=0, no state change.
5. Pending edge source 4 with enable[4]=1, then clear enable -> cpu_irq=0 next cycle, addr0 still reads 0x0010. Set enable again -> cpu_irq=1.
6. Assert reset_n=0 mid-claim with in_service=0x0003 -> readdata, cpu_irq, pending, in_service and enable all 0 asynchronously. After release, a level line still high -> pending set on the next cycle.
